pkt_csum_tx: RTL and testbench

Packet transmitter that appends a 16-bit two's-complement checksum word to every packet, so that the wrapping sum of all words, checksum included, equals zero. It sits upstream of the checksum-checking, drop-on-error packet FIFO and produces exactly the sop/eop/vld stream that FIFO accepts. It also enforces framing on the source side: a maximum packet length and recovery from missing or stray sop/eop. Optional checksum corruption lets the bench exercise the receiver's drop path.

---
 rtl/pkt_csum_tx_pkg.sv | 18 +
 rtl/pkt_csum_tx.sv | 144 ++++++++++++++
 tb/tb_pkt_csum_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_csum_tx_pkg.sv
// Shared definitions for the checksum-appending packet transmitter: FSM state
// encoding and the checksum function that downstream checkers reuse.
package pkt_csum_tx_pkg;

  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } state_e;

  // Two's-complement negation: appending this word makes the packet sum zero.
  function automatic logic [CSUM_W-1:0] neg_sum(input logic [CSUM_W-1:0] sum);
    return ~sum + CSUM_W'(1);
  endfunction

endpackage

// File: rtl/pkt_csum_tx.sv
// Packet transmitter: forwards payload words one cycle late and closes every
// packet with a checksum word so the wrapping sum of the packet is zero.
module pkt_csum_tx
  import pkt_csum_tx_pkg::*;
#(
  parameter int DW      = 16,
  parameter int MAX_LEN = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  output logic          din_rdy,
  input  logic          csum_inj,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          proto_err,
  output logic [15:0]   pkt_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          dout_sop_q, dout_sop_d;
  logic          dout_eop_q, dout_eop_d;
  logic          proto_err_q, proto_err_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  logic          accept;
  logic          len_last;
  logic [DW-1:0] csum_word;

  // The only stall is the single cycle spent emitting the checksum.
  assign din_rdy   = (state_q != CSUM);
  assign accept    = din_vld & din_rdy;
  assign len_last  = (len_q == LW'(MAX_LEN - 1));
  assign csum_word = DW'(neg_sum(CSUM_W'(sum_q))) ^ {{(DW-1){1'b0}}, csum_inj};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    len_d       = len_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    dout_sop_d  = 1'b0;
    dout_eop_d  = 1'b0;
    proto_err_d = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (din_sop) begin
            dout_d     = din;
            dout_vld_d = 1'b1;
            dout_sop_d = 1'b1;
            sum_d      = din;
            len_d      = LW'(1);
            state_d    = (din_eop || (MAX_LEN == 1)) ? CSUM : DATA;
          end else begin
            // Word outside any packet: drop it.
            proto_err_d = 1'b1;
          end
        end
      end

      DATA: begin
        if (accept) begin
          if (!din_sop) begin
            dout_d     = din;
            dout_vld_d = 1'b1;
            sum_d      = sum_q + din;
            len_d      = len_q + LW'(1);
            if (din_eop) begin
              state_d = CSUM;
            end else if (len_last) begin
              // Length limit reached without eop: force the packet closed.
              state_d     = CSUM;
              proto_err_d = 1'b1;
            end
          end else begin
            // Stray sop: drop it and close the packet that is still open.
            proto_err_d = 1'b1;
            state_d     = CSUM;
          end
        end
      end

      CSUM: begin
        dout_d     = csum_word;
        dout_vld_d = 1'b1;
        dout_eop_d = 1'b1;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      len_q       <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      proto_err_q <= proto_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_sop  = dout_sop_q;
  assign dout_eop  = dout_eop_q;
  assign proto_err = proto_err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_csum_tx.sv
// Self-checking bench for pkt_csum_tx: directed framing scenarios followed by
// random traffic, all compared cycle by cycle against a packet-level model.
module tb_pkt_csum_tx;

  localparam int DW      = 16;
  localparam int MAX_LEN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_vld, din_sop, din_eop, csum_inj;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_sop, dout_eop, proto_err;
  logic [15:0]   pkt_cnt;

  always #5 clk = ~clk;

  pkt_csum_tx #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_rdy  (din_rdy),
    .csum_inj (csum_inj),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .proto_err(proto_err),
    .pkt_cnt  (pkt_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Packet-level reference: the open packet is a list of words; its checksum
  // is the negated total of that list.
  bit          m_open, m_closing;
  int unsigned m_words[$];
  logic [15:0] m_dout;
  bit          m_vld, m_sop, m_eop, m_err;
  int unsigned m_cnt;

  function automatic logic [15:0] model_csum();
    logic [31:0] total = 0;
    logic [31:0] neg;
    foreach (m_words[i]) total += m_words[i];
    neg = 32'd0 - total;
    return neg[15:0];
  endfunction

  task automatic model_reset();
    m_open = 0; m_closing = 0; m_words.delete();
    m_dout = '0; m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit vld, input bit sop, input bit eop,
                            input logic [15:0] d, input bit inj, output bit acc);
    m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0; acc = 0;
    if (m_closing) begin
      m_dout = model_csum() ^ 16'(inj);
      m_vld = 1; m_eop = 1; m_cnt++;
      m_closing = 0; m_open = 0; m_words.delete();
    end else if (vld) begin
      acc = 1;
      if (!m_open) begin
        if (sop) begin
          m_words.delete(); m_words.push_back(d);
          m_dout = d; m_vld = 1; m_sop = 1; m_open = 1;
          if (eop || m_words.size() == MAX_LEN) m_closing = 1;
        end else begin
          m_err = 1;
        end
      end else if (!sop) begin
        m_words.push_back(d);
        m_dout = d; m_vld = 1;
        if (eop) m_closing = 1;
        else if (m_words.size() == MAX_LEN) begin m_closing = 1; m_err = 1; end
      end else begin
        m_err = 1; m_closing = 1;
      end
    end
  endtask

  logic [15:0] last_csum;
  int          err_seen, rdy_low;

  task automatic cycle(input bit vld, input bit sop, input bit eop,
                       input logic [15:0] d, input bit inj, output bit acc);
    @(negedge clk);
    din_vld = vld; din_sop = sop; din_eop = eop; din = d; csum_inj = inj;
    #1;
    check("din_rdy", din_rdy, !m_closing);
    if (!din_rdy) rdy_low++;
    model_step(vld, sop, eop, d, inj, acc);
    @(posedge clk);
    #1;
    check("dout_vld", dout_vld, m_vld);
    check("dout_sop", dout_sop, m_sop);
    check("dout_eop", dout_eop, m_eop);
    check("dout", dout, m_dout);
    check("proto_err", proto_err, m_err);
    check("pkt_cnt", pkt_cnt, m_cnt[15:0]);
    if (dout_vld && dout_eop) last_csum = dout;
    if (proto_err) err_seen++;
  endtask

  task automatic idle(input int n, input bit inj);
    bit acc;
    repeat (n) cycle(0, 0, 0, '0, inj, acc);
  endtask

  // Upstream behaviour: hold the word until it is accepted (bounded).
  task automatic send(input bit sop, input bit eop, input logic [15:0] d);
    bit acc = 0;
    int tries = 0;
    while (!acc && tries < 4) begin
      cycle(1, sop, eop, d, 0, acc);
      tries++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, dout, 16'h0);
    check({tag, "_vld"}, dout_vld, 1'b0);
    check({tag, "_sop"}, dout_sop, 1'b0);
    check({tag, "_eop"}, dout_eop, 1'b0);
    check({tag, "_err"}, proto_err, 1'b0);
    check({tag, "_cnt"}, pkt_cnt, 16'h0);
    check({tag, "_rdy"}, din_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst_n = 0; din = '0; din_vld = 0; din_sop = 0; din_eop = 0; csum_inj = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    // Basic 3-word packet.
    rdy_low = 0;
    send(1, 0, 16'h0001); send(0, 0, 16'h0002); send(0, 1, 16'h0003);
    idle(2, 0);
    check("t1_csum", last_csum, 16'hFFFA);
    check("t1_rdy_low", rdy_low, 1);
    check("t1_pkt_cnt", pkt_cnt, 16'd1);

    // Single-word packet, next sop presented immediately.
    send(1, 1, 16'h8000);
    send(1, 1, 16'h0005);
    check("t2_csum", last_csum, 16'h8000);
    idle(2, 0);
    check("t2_csum_b", last_csum, 16'hFFFB);

    // Corrupted checksum, then a clean packet.
    send(1, 0, 16'h0001); send(0, 0, 16'h0002); send(0, 1, 16'h0003);
    idle(1, 1);
    idle(1, 0);
    check("t3_csum_inj", last_csum, 16'hFFFB);
    send(1, 1, 16'h0010);
    idle(2, 0);
    check("t3_csum_clean", last_csum, 16'hFFF0);

    // Six words, no eop, MAX_LEN=4: forced close plus two stray drops.
    err_seen = 0;
    send(1, 0, 16'h0001);
    for (int i = 2; i <= 6; i++) send(0, 0, 16'(i));
    idle(2, 0);
    check("t4_csum", last_csum, 16'hFFF6);
    check("t4_errs", err_seen, 3);

    // Stray sop after two payload words.
    err_seen = 0;
    send(1, 0, 16'h0100); send(0, 0, 16'h0200); send(1, 0, 16'h0300);
    idle(2, 0);
    check("t5_csum", last_csum, 16'hFD00);
    check("t5_errs", err_seen, 1);
    check("t5_pkt_cnt", pkt_cnt, 16'd7);

    // Reset mid-packet, then a clean packet.
    send(1, 0, 16'h1234); send(0, 0, 16'h1111);
    @(negedge clk);
    din_vld = 0; din_sop = 0; din_eop = 0; rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    send(1, 0, 16'h0007); send(0, 1, 16'h0009);
    idle(2, 0);
    check("t6_csum", last_csum, 16'hFFF0);
    check("t6_pkt_cnt", pkt_cnt, 16'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
            16'($urandom), ($urandom % 8) == 0, acc);
    end
    idle(3, 0);
    check("final_pkt_cnt", pkt_cnt, m_cnt[15:0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
